// File: rtl/mem_responder.sv
// Memory-side responder: unified word array serving one load/store at a time over valid/ready channels.
// Optional build macro MEM_MISALIGN_CHK_EN flags misaligned half/word accesses with rsp_err.
module mem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              lat_we;
    logic              lat_uns;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_size;
    logic [31:0]       lat_wdata;

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       old_word;
    logic [31:0]       wr_word;
    logic [31:0]       ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              commit;
    logic              misaligned;

    assign req_ready = (state == IDLE) && reset;

    // A waiting request commits once its wait count has drained to zero.
    assign commit   = (state == BUSY) && (count == '0);
    assign idx      = IDX_W'(32'(lat_addr[ADDR_W-1:2]) % DEPTH);
    assign old_word = mem[idx];
    assign ld_byte  = old_word[{lat_addr[1:0], 3'b000} +: 8];
    assign ld_half  = old_word[{lat_addr[1], 4'b0000} +: 16];

`ifdef MEM_MISALIGN_CHK_EN
    assign misaligned = ((lat_size == 2'b01) && lat_addr[0]) ||
                        (lat_size[1] && (lat_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Aligned, extended load result.
    always_comb begin
        ld_data = old_word;
        case (lat_size)
            2'b00:   ld_data = lat_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = lat_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = old_word;
        endcase
    end

    // Byte-lane merge of store data into the existing word.
    always_comb begin
        wr_word = old_word;
        case (lat_size)
            2'b00:   wr_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            2'b01:   wr_word[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: wr_word = lat_wdata;
        endcase
    end

    // Array contents survive reset; a store is written only on its commit edge.
    always_ff @(posedge clk) begin
        if (reset && commit && lat_we && !misaligned) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_addr  <= req_addr;
                        lat_size  <= req_size;
                        lat_wdata <= req_wdata;
                        count     <= CNT_W'(WAIT_CYCLES);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= misaligned;
                        rsp_rdata <= (lat_we || misaligned) ? 32'h0 : ld_data;
                        state     <= RESP;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
